fetch_fd_stage: RTL and testbench

Fetch stage plus Fetch/Decode pipeline register for the MINI-RISC pipeline. It consumes the hazard unit's `stall_F`, `flush_F` and `branch_en` controls, drives a synchronous instruction memory, and presents instruction, PC and valid to the Decode stage. A one-entry skid buffer guarantees that no fetched word is lost while the front end is stalled.

---
 rtl/fetch_fd_stage_pkg.sv | 16 +
 rtl/fetch_fd_stage_if.sv | 30 +++
 rtl/fetch_fd_stage_skid_buf.sv | 37 +++
 rtl/fetch_fd_stage.sv | 121 ++++++++++++
 tb/tb_fetch_fd_stage.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/fetch_fd_stage_pkg.sv
// Shared constants and types for the MINI-RISC fetch stage.
//   NOP_INSTR        : encoding loaded into the FD register for a bubble
//   RESET_PC_DEFAULT : default fetch address after reset
//   fetch_state_e    : front-end FSM states
package fetch_fd_stage_pkg;

  localparam logic [15:0] NOP_INSTR        = 16'h0000;
  localparam int          RESET_PC_DEFAULT = 0;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,  // nothing in flight; next advance yields a bubble
    ST_RUN  = 2'd1,  // streaming one word per cycle
    ST_HOLD = 2'd2   // frozen by stall/flush; skid word delivered first on release
  } fetch_state_e;

endpackage

// File: rtl/fetch_fd_stage_if.sv
// Bus bundle between the fetch stage and its surroundings.
//   hazard controls : stall_F, flush_F, branch_en, branch_target
//   imem port       : imem_addr, imem_en (out of fetch), imem_rdata (into fetch)
//   decode side     : instr_D, pc_D, valid_D
// master = the fetch stage, slave = hazard unit / memory / decode side.
interface fetch_fd_stage_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
);
  logic               stall_F;
  logic               flush_F;
  logic               branch_en;
  logic [PC_W-1:0]    branch_target;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_en;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr_D;
  logic [PC_W-1:0]    pc_D;
  logic               valid_D;

  modport master (
    input  stall_F, flush_F, branch_en, branch_target, imem_rdata,
    output imem_addr, imem_en, instr_D, pc_D, valid_D
  );

  modport slave (
    output stall_F, flush_F, branch_en, branch_target, imem_rdata,
    input  imem_addr, imem_en, instr_D, pc_D, valid_D
  );
endinterface

// File: rtl/fetch_fd_stage_skid_buf.sv
// One-entry skid buffer for the fetch stage.
//   clk, rst   : clock, asynchronous active-high reset
//   capture_i  : store data_i and mark the entry valid
//   clear_i    : drop the stored entry (capture has priority)
//   data_i     : word to capture (instruction memory read data)
//   skid_instr_o, skid_v_o : stored word and its valid flag
module fetch_fd_stage_skid_buf #(
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               capture_i,
  input  logic               clear_i,
  input  logic [INSTR_W-1:0] data_i,
  output logic [INSTR_W-1:0] skid_instr_o,
  output logic               skid_v_o
);

  logic [INSTR_W-1:0] skid_instr_q;
  logic               skid_v_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_instr_q <= '0;
      skid_v_q     <= 1'b0;
    end else if (capture_i) begin
      skid_instr_q <= data_i;
      skid_v_q     <= 1'b1;
    end else if (clear_i) begin
      skid_v_q     <= 1'b0;
    end
  end

  assign skid_instr_o = skid_instr_q;
  assign skid_v_o     = skid_v_q;

endmodule

// File: rtl/fetch_fd_stage.sv
// Fetch stage plus Fetch/Decode pipeline register.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fetch_fd_stage_if master port (hazard controls in,
//              synchronous imem port, FD register outputs to Decode)
// Fetch address pc_F is issued to a one-cycle-latency memory; the word for
// pc_M arrives on imem_rdata the following cycle. While the front end is
// frozen that word is parked in the skid buffer so nothing is lost.
module fetch_fd_stage
  import fetch_fd_stage_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
  input  logic                   clk,
  input  logic                   rst,
  fetch_fd_stage_if.master       bus
);

  localparam logic [INSTR_W-1:0] NOP_W = INSTR_W'(NOP_INSTR);

  fetch_state_e       state_q,     state_d;
  logic [PC_W-1:0]    pc_f_q,      pc_f_d;
  logic [PC_W-1:0]    pc_m_q,      pc_m_d;
  logic               m_v_q,       m_v_d;
  logic [INSTR_W-1:0] instr_d_q,   instr_d_d;
  logic [PC_W-1:0]    pc_d_q,      pc_d_d;
  logic               valid_d_q,   valid_d_d;

  logic               skid_capture;
  logic               skid_clear;
  logic [INSTR_W-1:0] skid_instr;
  logic               skid_v;

  fetch_fd_stage_skid_buf #(.INSTR_W(INSTR_W)) u_skid (
    .clk          (clk),
    .rst          (rst),
    .capture_i    (skid_capture),
    .clear_i      (skid_clear),
    .data_i       (bus.imem_rdata),
    .skid_instr_o (skid_instr),
    .skid_v_o     (skid_v)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FILL;
      pc_f_q    <= RESET_PC;
      pc_m_q    <= '0;
      m_v_q     <= 1'b0;
      instr_d_q <= NOP_W;
      pc_d_q    <= '0;
      valid_d_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_f_q    <= pc_f_d;
      pc_m_q    <= pc_m_d;
      m_v_q     <= m_v_d;
      instr_d_q <= instr_d_d;
      pc_d_q    <= pc_d_d;
      valid_d_q <= valid_d_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_f_d       = pc_f_q;
    pc_m_d       = pc_m_q;
    m_v_d        = m_v_q;
    instr_d_d    = instr_d_q;
    pc_d_d       = pc_d_q;
    valid_d_d    = valid_d_q;
    skid_capture = 1'b0;
    skid_clear   = 1'b0;

    if (bus.branch_en) begin
      // Redirect beats stall/flush: everything fetched so far is wrong-path.
      pc_f_d     = bus.branch_target;
      m_v_d      = 1'b0;
      skid_clear = 1'b1;
      valid_d_d  = 1'b0;
      instr_d_d  = NOP_W;
      state_d    = ST_FILL;
    end else if (bus.flush_F || bus.stall_F) begin
      // imem_rdata is only meaningful for pc_M on the first frozen cycle
      // (m_v still set); park it so it survives until release.
      skid_capture = m_v_q && !skid_v;
      m_v_d        = 1'b0;
      if (bus.flush_F) begin
        valid_d_d = 1'b0;
        instr_d_d = NOP_W;
      end
      state_d = ST_HOLD;
    end else begin
      if (skid_v) begin
        instr_d_d = skid_instr;
        pc_d_d    = pc_m_q;
        valid_d_d = 1'b1;
      end else if (m_v_q) begin
        instr_d_d = bus.imem_rdata;
        pc_d_d    = pc_m_q;
        valid_d_d = 1'b1;
      end else begin
        instr_d_d = NOP_W;
        valid_d_d = 1'b0;
      end
      pc_m_d     = pc_f_q;
      m_v_d      = 1'b1;
      skid_clear = 1'b1;
      pc_f_d     = pc_f_q + 1'b1;
      state_d    = ST_RUN;
    end
  end

  assign bus.imem_addr = pc_f_q;
  assign bus.imem_en   = !(bus.stall_F || bus.flush_F || bus.branch_en);
  assign bus.instr_D   = instr_d_q;
  assign bus.pc_D      = pc_d_q;
  assign bus.valid_D   = valid_d_q;

endmodule

// File: tb/tb_fetch_fd_stage.sv
// Directed bench for fetch_fd_stage: free run, flush, stall, branch during
// stall, branch clearing a full skid buffer, PC wrap and asynchronous reset.
// Memory holds mem[i] = 16'h1000 + i. Checks happen 1 ns after each edge.
module tb_fetch_fd_stage;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  fetch_fd_stage_if #(.PC_W(8), .INSTR_W(16)) bus ();

  fetch_fd_stage #(.PC_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] mem [256];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
  end

  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic f, input logic b, input logic [7:0] tgt);
    bus.stall_F       = s;
    bus.flush_F       = f;
    bus.branch_en     = b;
    bus.branch_target = tgt;
  endtask

  task automatic chk(input string tag, input logic v, input logic [7:0] pc, input logic [15:0] ins);
    $display("%-14s valid_D=%0b pc_D=%h instr_D=%h", tag, bus.valid_D, bus.pc_D, bus.instr_D);
    n_checks++;
    assert (bus.valid_D === v) else begin
      n_errors++;
      $error("FAIL %s valid_D observed %0b expected %0b", tag, bus.valid_D, v);
    end
    n_checks++;
    assert (bus.pc_D === pc) else begin
      n_errors++;
      $error("FAIL %s pc_D observed %h expected %h", tag, bus.pc_D, pc);
    end
    n_checks++;
    assert (bus.instr_D === ins) else begin
      n_errors++;
      $error("FAIL %s instr_D observed %h expected %h", tag, bus.instr_D, ins);
    end
  endtask

  task automatic chk_bus(input string tag, input logic en, input logic [7:0] addr);
    #1;
    $display("%-14s imem_en=%0b imem_addr=%h", tag, bus.imem_en, bus.imem_addr);
    n_checks++;
    assert (bus.imem_en === en) else begin
      n_errors++;
      $error("FAIL %s imem_en observed %0b expected %0b", tag, bus.imem_en, en);
    end
    n_checks++;
    assert (bus.imem_addr === addr) else begin
      n_errors++;
      $error("FAIL %s imem_addr observed %h expected %h", tag, bus.imem_addr, addr);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    tick(); tick();
    chk("reset", 1'b0, 8'h00, 16'h0000);
    chk_bus("reset_bus", 1'b1, 8'h00);

    // Free run: reset released between edges, this is cycle 0.
    rst = 1'b0;
    chk("run_c0", 1'b0, 8'h00, 16'h0000);
    chk_bus("run_c0_bus", 1'b1, 8'h00);
    tick(); chk("run_c1", 1'b0, 8'h00, 16'h0000);
    chk_bus("run_c1_bus", 1'b1, 8'h01);
    tick(); chk("run_c2", 1'b1, 8'h00, 16'h1000);
    tick(); chk("run_c3", 1'b1, 8'h01, 16'h1001);
    tick(); chk("run_c4", 1'b1, 8'h02, 16'h1002);

    // Flush alone for one cycle while pc_D = 2.
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    chk_bus("flush_bus", 1'b0, 8'h04);
    tick(); drive(1'b0, 1'b0, 1'b0, 8'h00);
    chk("flush_bubble", 1'b0, 8'h02, 16'h0000);
    tick(); chk("flush_after", 1'b1, 8'h03, 16'h1003);
    tick(); chk("pre_stall", 1'b1, 8'h04, 16'h1004);

    // Stall for three cycles while pc_D = 4.
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    tick(); chk("stall_1", 1'b1, 8'h04, 16'h1004);
    chk_bus("stall_bus", 1'b0, 8'h06);
    tick(); chk("stall_2", 1'b1, 8'h04, 16'h1004);
    tick(); drive(1'b0, 1'b0, 1'b0, 8'h00);
    chk("stall_3", 1'b1, 8'h04, 16'h1004);
    tick(); chk("release_1", 1'b1, 8'h05, 16'h1005);
    tick(); chk("release_2", 1'b1, 8'h06, 16'h1006);

    // Branch together with stall: redirect wins.
    drive(1'b1, 1'b0, 1'b1, 8'h40);
    chk_bus("branch_bus", 1'b0, 8'h08);
    tick(); drive(1'b0, 1'b0, 1'b0, 8'h00);
    chk("branch_b1", 1'b0, 8'h06, 16'h0000);
    chk_bus("branch_addr", 1'b1, 8'h40);
    tick(); chk("branch_b2", 1'b0, 8'h06, 16'h0000);
    tick(); chk("branch_tgt", 1'b1, 8'h40, 16'h1040);
    tick(); chk("branch_next", 1'b1, 8'h41, 16'h1041);

    // Fill the skid buffer, then redirect to FE: the parked word must vanish.
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    tick(); chk("skid_full", 1'b1, 8'h41, 16'h1041);
    drive(1'b1, 1'b0, 1'b1, 8'hFE);
    tick(); drive(1'b0, 1'b0, 1'b0, 8'h00);
    chk("wrap_b1", 1'b0, 8'h41, 16'h0000);
    tick(); chk("wrap_b2", 1'b0, 8'h41, 16'h0000);
    tick(); chk("wrap_fe", 1'b1, 8'hFE, 16'h10FE);
    tick(); chk("wrap_ff", 1'b1, 8'hFF, 16'h10FF);
    tick(); chk("wrap_00", 1'b1, 8'h00, 16'h1000);
    tick(); chk("wrap_01", 1'b1, 8'h01, 16'h1001);

    // Asynchronous reset between edges while the skid buffer is full.
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    tick(); chk("skid_full2", 1'b1, 8'h01, 16'h1001);
    #3 rst = 1'b1;
    #1 chk("async_rst", 1'b0, 8'h00, 16'h0000);
    chk_bus("async_rst_bus", 1'b0, 8'h00);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    chk("rst2_c0", 1'b0, 8'h00, 16'h0000);
    chk_bus("rst2_c0_bus", 1'b1, 8'h00);
    tick(); chk("rst2_c1", 1'b0, 8'h00, 16'h0000);
    tick(); chk("rst2_c2", 1'b1, 8'h00, 16'h1000);
    tick(); chk("rst2_c3", 1'b1, 8'h01, 16'h1001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
